// File: rtl/nco_pkg.sv
// nco_pkg: quadrant type, LFSR dither constants and the quarter-wave table generator
// shared by nco_lut and nco_quarter_lut.
package nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  localparam int unsigned        LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

  function automatic quadrant_e quad_next(input quadrant_e q);
    return quadrant_e'(q + 2'd1);
  endfunction

  // Odd quadrants read the table backwards
  function automatic logic quad_mirrored(input quadrant_e q);
    return (q == Q1) || (q == Q3);
  endfunction

  // Lower half-plane gives a negative sample
  function automatic logic quad_negated(input quadrant_e q);
    return (q == Q2) || (q == Q3);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Half-step sample points keep every entry non-zero and make ~addr an exact mirror
  function automatic int unsigned lut_entry(input int unsigned k,
                                            input int unsigned aw,
                                            input int unsigned ow);
    real amp;
    real ang;
    amp = (2.0 ** (ow - 1)) - 1.0;
    ang = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / (2.0 ** aw);
    return $unsigned($rtoi(amp * $sin(ang) + 0.5));
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: single-port registered quarter-wave ROM holding 2^LUT_AW unsigned
// sine magnitudes of OUT_W-1 bits, contents generated at elaboration.
module nco_quarter_lut import nco_pkg::*; #(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [OUT_W-2:0]  data_o
);

  localparam int unsigned DEPTH = 1 << LUT_AW;

  logic [OUT_W-2:0] rom [DEPTH];
  logic [OUT_W-2:0] data_q;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_rom
    assign rom[k] = (OUT_W-1)'(lut_entry(k, LUT_AW, OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/nco_lut.sv
// nco_lut: phase-accumulator NCO producing signed sine/cosine through a quarter-wave LUT,
// 3-cycle phase-to-sample latency. Define NCO_DITHER_EN to add LFSR phase dither.
module nco_lut import nco_pkg::*; #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc_ld,
  input  logic [WIDTH-1:0] phase_inc,
  input  logic [WIDTH-1:0] phase_ofs,
  input  logic             sync_clr,
  output logic [OUT_W-1:0] sin_out,
  output logic [OUT_W-1:0] cos_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] phase_accum
);

  localparam int unsigned VLD_DLY = 4;

  logic [WIDTH-1:0]   inc_q, inc_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   phase_sum;
  quadrant_e          qs_d, qc_d;
  logic [LUT_AW-1:0]  a_d;
  quadrant_e          qs1_q, qc1_q;
  logic [LUT_AW-1:0]  a1_q;
  logic [LUT_AW-1:0]  addr_s, addr_c;
  logic [OUT_W-2:0]   mag_s, mag_c;
  quadrant_e          qs2_q, qc2_q;
  logic [OUT_W-1:0]   sin_d, cos_d;
  logic [OUT_W-1:0]   sin_q, cos_q;
  logic [VLD_DLY-1:0] vld_q, vld_d;

  // S0: clear beats enable; a new increment is only seen from the following cycle
  always_comb begin
    inc_d = inc_q;
    acc_d = acc_q;
    if (inc_ld) begin
      inc_d = phase_inc;
    end
    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + inc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= '0;
      acc_q <= '0;
    end else begin
      inc_q <= inc_d;
      acc_q <= acc_d;
    end
  end

  // S1: offset (and optional dither) applied outside the accumulator loop
`ifdef NCO_DITHER_EN
  localparam int unsigned DITH_SH = WIDTH - 2 - LUT_AW - LFSR_W;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign phase_sum = acc_q + phase_ofs + (WIDTH'(lfsr_q) << DITH_SH);
`else
  assign phase_sum = acc_q + phase_ofs;
`endif

  if (WIDTH > LUT_AW + 2) begin : g_cut
    logic unused_below_cut;
    assign unused_below_cut = ^phase_sum[WIDTH-3-LUT_AW:0];
  end

  assign qs_d = quadrant_e'(phase_sum[WIDTH-1 -: 2]);
  assign qc_d = quad_next(qs_d);
  assign a_d  = phase_sum[WIDTH-3 -: LUT_AW];

  // S2: mirror the address before the ROM so the sign is the only thing left for S3
  assign addr_s = quad_mirrored(qs1_q) ? ~a1_q : a1_q;
  assign addr_c = quad_mirrored(qc1_q) ? ~a1_q : a1_q;

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut_sin (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr_s),
    .data_o (mag_s)
  );

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut_cos (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr_c),
    .data_o (mag_c)
  );

  // S3: magnitude never exceeds 2^(OUT_W-1)-1, so negation cannot overflow
  assign sin_d = quad_negated(qs2_q) ? -{1'b0, mag_s} : {1'b0, mag_s};
  assign cos_d = quad_negated(qc2_q) ? -{1'b0, mag_c} : {1'b0, mag_c};

  assign vld_d = {vld_q[VLD_DLY-2:0], en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs1_q <= Q0;
      qc1_q <= Q0;
      a1_q  <= '0;
      qs2_q <= Q0;
      qc2_q <= Q0;
      sin_q <= '0;
      cos_q <= '0;
      vld_q <= '0;
    end else begin
      qs1_q <= qs_d;
      qc1_q <= qc_d;
      a1_q  <= a_d;
      qs2_q <= qs1_q;
      qc2_q <= qc1_q;
      sin_q <= sin_d;
      cos_q <= cos_d;
      vld_q <= vld_d;
    end
  end

  assign sin_out     = sin_q;
  assign cos_out     = cos_q;
  assign out_valid   = vld_q[VLD_DLY-1];
  assign phase_accum = acc_q;

endmodule
